maximum_stream_reducer: RTL and testbench



---
 rtl/maximum_stream_reducer.sv | 163 ++++++++++++++++
 tb/tb_maximum_stream_reducer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/maximum_stream_reducer.sv
// Streaming max/min reducer: scans one frame of signed beats and holds the
// extreme active value, its beat index and an overflow flag until the consumer takes it.
module maximum_stream_reducer #(
    parameter int NUMBER_SIZE = 4,
    parameter int INDEX_SIZE  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [NUMBER_SIZE-1:0] in_number,
    input  logic                          in_activation,
    input  logic                          in_last,
    input  logic                          find_min,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [NUMBER_SIZE-1:0] maximum,
    output logic                          maximum_activation,
    output logic [INDEX_SIZE-1:0]         maximum_index,
    output logic                          overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [INDEX_SIZE-1:0]  IDX_MAX  = {INDEX_SIZE{1'b1}};
    localparam logic [INDEX_SIZE-1:0]  IDX_ZERO = {INDEX_SIZE{1'b0}};
    localparam logic [INDEX_SIZE-1:0]  IDX_ONE  = {{(INDEX_SIZE-1){1'b0}}, 1'b1};
    localparam logic [NUMBER_SIZE-1:0] NUM_ZERO = {NUMBER_SIZE{1'b0}};

    state_t                          state_q, state_d;
    logic [INDEX_SIZE-1:0]           count_q, count_d;
    logic signed [NUMBER_SIZE-1:0]   best_q, best_d;
    logic [INDEX_SIZE-1:0]           best_idx_q, best_idx_d;
    logic                            active_q, active_d;
    logic                            mode_q, mode_d;
    logic                            overflow_q, overflow_d;
    logic                            out_valid_q, out_valid_d;

    logic                            accept_s;
    logic                            mode_s;
    logic                            better_s;
    logic                            take_s;

    // Beat qualification: mode comes straight from the input on the first beat only.
    always_comb begin
        accept_s = in_valid & ~out_valid_q;
        if (state_q == IDLE) begin
            mode_s = find_min;
        end else begin
            mode_s = mode_q;
        end
        if (mode_s) begin
            better_s = (in_number < best_q);
        end else begin
            better_s = (in_number > best_q);
        end
        // Strict comparison keeps the earliest index on ties.
        take_s = in_activation & (~active_q | better_s);
    end

    // Next-state and running-result update.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        active_d    = active_q;
        mode_d      = mode_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept_s) begin
                    mode_d = mode_s;
                    // Counter saturates so post-overflow beats report the top index.
                    if (count_q == IDX_MAX) begin
                        count_d = IDX_MAX;
                    end else begin
                        count_d = count_q + IDX_ONE;
                    end
                    if (take_s) begin
                        best_d     = in_number;
                        best_idx_d = count_q;
                        active_d   = 1'b1;
                    end else begin
                        best_d     = best_q;
                        best_idx_d = best_idx_q;
                        active_d   = active_q;
                    end
                    if ((count_q == IDX_MAX) && !in_last) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d    = IDLE;
                    count_d    = IDX_ZERO;
                    best_d     = NUM_ZERO;
                    best_idx_d = IDX_ZERO;
                    active_d   = 1'b0;
                    mode_d     = 1'b0;
                    overflow_d = 1'b0;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d    = IDLE;
                count_d    = IDX_ZERO;
                best_d     = NUM_ZERO;
                best_idx_d = IDX_ZERO;
                active_d   = 1'b0;
                mode_d     = 1'b0;
                overflow_d = 1'b0;
            end
        endcase
        out_valid_d = (state_d == HOLD);
    end

    // State registers; reset discards any partial or held frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= IDX_ZERO;
            best_q      <= NUM_ZERO;
            best_idx_q  <= IDX_ZERO;
            active_q    <= 1'b0;
            mode_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            active_q    <= active_d;
            mode_q      <= mode_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready           = ~out_valid_q;
    assign out_valid          = out_valid_q;
    assign maximum            = best_q;
    assign maximum_activation = active_q;
    assign maximum_index      = best_idx_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_maximum_stream_reducer.sv
// Directed bench for maximum_stream_reducer: default instance plus an
// INDEX_SIZE=2 instance sharing the same stimulus for the overflow frame.
module tb_maximum_stream_reducer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_activation = 1'b0;
    logic              in_last = 1'b0;
    logic              find_min = 1'b0;
    logic              out_ready = 1'b0;
    logic signed [3:0] in_number = 4'sd0;

    logic              in_ready_a, out_valid_a, act_a, ovf_a;
    logic signed [3:0] max_a;
    logic [7:0]        idx_a;
    logic              in_ready_b, out_valid_b, act_b, ovf_b;
    logic signed [3:0] max_b;
    logic [1:0]        idx_b;

    maximum_stream_reducer #(.NUMBER_SIZE(4), .INDEX_SIZE(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_number(in_number), .in_activation(in_activation), .in_last(in_last),
        .find_min(find_min), .out_valid(out_valid_a), .out_ready(out_ready),
        .maximum(max_a), .maximum_activation(act_a), .maximum_index(idx_a),
        .overflow(ovf_a)
    );

    maximum_stream_reducer #(.NUMBER_SIZE(4), .INDEX_SIZE(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_number(in_number), .in_activation(in_activation), .in_last(in_last),
        .find_min(find_min), .out_valid(out_valid_b), .out_ready(out_ready),
        .maximum(max_b), .maximum_activation(act_b), .maximum_index(idx_b),
        .overflow(ovf_b)
    );

    typedef struct {
        int mx;
        int idx;
        int act;
        int ovf;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int mx, input int idx, input int act, input int ovf);
        exp_t e;
        e.mx = mx; e.idx = idx; e.act = act; e.ovf = ovf;
        sb.push_back(e);
    endtask

    task automatic beat(input int n, input logic a, input logic l, input logic fm);
        int w;
        w = 0;
        in_valid = 1'b1; in_number = 4'(n); in_activation = a; in_last = l; find_min = fm;
        while (!in_ready_a && w < 20) begin
            cyc();
            w++;
        end
        chk("beat_ready", 32'(in_ready_a), 1);
        cyc();
        in_valid = 1'b0; in_last = 1'b0; in_activation = 1'b0;
    endtask

    task automatic result();
        int w;
        exp_t e;
        w = 0;
        while (!out_valid_a && w < 20) begin
            cyc();
            w++;
        end
        chk("res_out_valid", 32'(out_valid_a), 1);
        e = sb.pop_front();
        chk("res_maximum", 32'(max_a), e.mx);
        chk("res_index", 32'(idx_a), e.idx);
        chk("res_activation", 32'(act_a), e.act);
        chk("res_overflow", 32'(ovf_a), e.ovf);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        chk("hs_out_valid", 32'(out_valid_a), 0);
        chk("hs_in_ready", 32'(in_ready_a), 1);
    endtask

    initial begin
        #12;
        chk("rst_out_valid", 32'(out_valid_a), 0);
        chk("rst_maximum", 32'(max_a), 0);
        chk("rst_index", 32'(idx_a), 0);
        chk("rst_activation", 32'(act_a), 0);
        chk("rst_overflow", 32'(ovf_a), 0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready_a), 1);

        // Max mode with an ignored inactive beat and a tie at beats 3/4.
        push(5, 3, 1, 0);
        beat(3, 1'b1, 1'b0, 1'b0);
        beat(-2, 1'b1, 1'b0, 1'b0);
        beat(5, 1'b0, 1'b0, 1'b0);
        beat(5, 1'b1, 1'b0, 1'b0);
        chk("f1_valid_before_last", 32'(out_valid_a), 0);
        beat(5, 1'b1, 1'b1, 1'b0);
        chk("f1_latency", 32'(out_valid_a), 1);

        // Backpressure: next frame's first beat waits while the result is held.
        in_valid = 1'b1; in_number = -4'sd1; in_activation = 1'b1; in_last = 1'b0; find_min = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_in_ready", 32'(in_ready_a), 0);
            chk("bp_out_valid", 32'(out_valid_a), 1);
            chk("bp_maximum", 32'(max_a), 5);
            chk("bp_index", 32'(idx_a), 3);
        end
        result();

        // Min mode latched on beat 0; later find_min=0 is ignored.
        push(-8, 1, 1, 0);
        beat(-1, 1'b1, 1'b0, 1'b1);
        beat(-8, 1'b1, 1'b0, 1'b0);
        beat(-8, 1'b1, 1'b0, 1'b0);
        beat(7, 1'b1, 1'b1, 1'b0);
        result();

        // All-inactive frame.
        push(0, 0, 0, 0);
        beat(4, 1'b0, 1'b0, 1'b0);
        beat(-3, 1'b0, 1'b1, 1'b0);
        result();

        // One-beat frame.
        push(-5, 0, 1, 0);
        beat(-5, 1'b1, 1'b1, 1'b0);
        result();

        // Six beats: the 2-bit-index instance overflows and saturates its index.
        push(6, 5, 1, 0);
        beat(1, 1'b1, 1'b0, 1'b0);
        beat(2, 1'b1, 1'b0, 1'b0);
        beat(3, 1'b1, 1'b0, 1'b0);
        chk("ovf_b_before", 32'(ovf_b), 0);
        beat(-1, 1'b1, 1'b0, 1'b0);
        chk("ovf_b_set", 32'(ovf_b), 1);
        beat(0, 1'b1, 1'b0, 1'b0);
        beat(6, 1'b1, 1'b1, 1'b0);
        chk("ovf_b_valid", 32'(out_valid_b), 1);
        chk("ovf_b_maximum", 32'(max_b), 6);
        chk("ovf_b_index", 32'(idx_b), 3);
        chk("ovf_b_flag", 32'(ovf_b), 1);
        chk("ovf_b_activation", 32'(act_b), 1);
        result();
        chk("ovf_b_cleared", 32'(ovf_b), 0);

        // Reset during ACCUM discards the partial frame.
        beat(2, 1'b1, 1'b0, 1'b0);
        beat(3, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_maximum", 32'(max_a), 3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_maximum", 32'(max_a), 0);
        chk("midrst_index", 32'(idx_a), 0);
        chk("midrst_activation", 32'(act_a), 0);
        chk("midrst_out_valid", 32'(out_valid_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("postrst_no_result", 32'(out_valid_a), 0);
        end
        push(1, 0, 1, 0);
        beat(1, 1'b1, 1'b1, 1'b0);
        result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
